id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the RV32I core, directly downstream of the register file's combinational read ports (data_a/data_b).
- Selects each source operand from the register file or from bypass sources, then registers it with the decoded fields into the EX-stage pipeline register.
- Detects load-use hazards, stalls the front end and inserts bubbles; handles branch flush.
- Provides a saturating stall counter.

Parameters:
XLEN, 32, datapath width
CTRL_W, 8, width of opaque ALU/branch control bundle passed through
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1, id_rs2  in  5  source register addresses (also drive register file AddrA/AddrB)
id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
id_rd  in  5  destination register
id_imm  in  XLEN  decoded immediate
id_ctrl  in  CTRL_W  control bundle
id_reg_wen, id_mem_read, id_mem_write  in  1  decoded write-back/load/store flags
rf_data_a, rf_data_b  in  XLEN  register file read data for rs1/rs2
ex_result  in  XLEN  ALU result of instruction currently held in this stage's output register
mem_rd  in  5  MEM-stage destination
mem_reg_wen  in  1  MEM-stage writes rd
mem_data  in  XLEN  final MEM-stage value, including load data
wb_rd  in  5  WB-stage destination (same values presented to register file AddrD)
wb_reg_wen  in  1  WB-stage write enable (same as register file RegWEn)
wb_data  in  XLEN  WB-stage write data
flush  in  1  branch/jump taken in EX; ID instruction is wrong-path
stall  out  1  hold PC and IF/ID register this cycle (combinational)
ex_valid, ex_reg_wen, ex_mem_read, ex_mem_write  out  1  registered flags
ex_pc, ex_op_a, ex_op_b, ex_imm  out  XLEN  registered fields/operands
ex_rd  out  5  registered destination
ex_ctrl  out  CTRL_W  registered control
stall_cnt  out  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs = 0; stall_cnt = 0. stall is combinational, so it is 0 while ex_valid = 0.
- Operand select, per source s ∈ {rs1, rs2}, highest priority first:
  1. s == 0 → 0.
  2. ex_valid & ex_reg_wen & !ex_mem_read & ex_rd == s → ex_result.
  3. mem_reg_wen & mem_rd == s → mem_data.
  4. wb_reg_wen & wb_rd == s → wb_data. Required: the register file writes at the clock edge and its read is combinational, so without this bypass a same-cycle read returns the old value.
  5. Otherwise rf_data_a / rf_data_b.
- Load-use hazard: haz = id_valid & ex_valid & ex_mem_read & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- stall = haz & !flush.
- Register update each rising edge:
  - flush = 1: bubble (ex_valid, ex_reg_wen, ex_mem_read, ex_mem_write = 0; all other ex_* fields = 0). Flush overrides stall.
  - else haz: bubble. The ID instruction is held upstream and re-evaluated next cycle; by then the load is in MEM and is bypassed via mem_data.
  - else !id_valid: bubble.
  - else: capture all id_* fields and the selected operands. ex_op_a = selected rs1 value; ex_op_b = selected rs2 value.
- Bubble rule: on a bubble, every control output is cleared, so a bubble never writes the register file or memory.
- Latency: 1 cycle from ID to ex_*. A load-use hazard costs exactly 1 bubble cycle.
- stall_cnt: increments on each edge where stall = 1; holds at all-ones (saturates, no wrap).
- id_use_rsN = 0: that source never raises a hazard. Its operand value is still selected and captured but is don't-care downstream.
- Reset mid-stall: outputs clear immediately; stall drops with ex_valid.

Test Plan:
- Reset then pass-through: x5 = 0x1234 in register file, no writers in flight; ID addi x6, x5, imm = 7 → next cycle ex_op_a = 0x1234, ex_imm = 7, ex_rd = 6, ex_valid = 1.
- Forward priority: ex_rd = mem_rd = wb_rd = 5, all writing; ex_result = 0xA, mem_data = 0xB, wb_data = 0xC; ID reads x5 → ex_op_a = 0xA. Remove EX writer → 0xB. Remove MEM writer → 0xC. rs1 = 0 with all writers targeting x0 → 0.
- WB same-cycle bypass: wb_reg_wen = 1, wb_rd = 7, wb_data = 0xDEAD, rf_data_b stale = 0 → ex_op_b = 0xDEAD.
- Load-use: lw x8 in EX; ID add x9, x8, x1 → stall = 1 for one cycle, bubble (ex_valid = 0), stall_cnt = 1. Next cycle mem_data = 0x55 → ex_op_a = 0x55.
- Flush vs stall: hazard and flush asserted together → stall = 0, bubble, stall_cnt unchanged.
- Counter saturation: with CNT_W = 4, 20 consecutive stall cycles → stall_cnt = 15. Assert rst_n low mid-sequence → all outputs 0 asynchronously.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Decode-to-execute pipeline stage of the RV32I core. It sits directly
//   downstream of the register file's combinational read ports. For each
//   source operand it picks the register file value or a bypassed result,
//   then registers the operands together with the decoded fields into the
//   EX-stage pipeline register. It also detects load-use hazards, stalls
//   the front end, inserts bubbles, handles branch flush and counts stall
//   cycles in a saturating counter.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_*                        decoded instruction currently in ID
//   rf_data_a / rf_data_b       register file read data for rs1 / rs2
//   ex_result                   ALU result of the instruction held in ex_*
//   mem_rd/mem_reg_wen/mem_data MEM-stage writer (value includes load data)
//   wb_rd/wb_reg_wen/wb_data    WB-stage writer (same as register file write)
//   flush                       EX resolved a taken branch/jump
//   stall                       hold PC and IF/ID this cycle (combinational)
//   ex_*                        EX-stage pipeline register
//   stall_cnt                   saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_wen,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [XLEN-1:0]   rf_data_a,
    input  logic [XLEN-1:0]   rf_data_b,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [4:0]        mem_rd,
    input  logic              mem_reg_wen,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [4:0]        wb_rd,
    input  logic              wb_reg_wen,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_reg_wen,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic            hazard;
    logic            bubble;
    logic            exFwdOk;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;

    // Bypass priority: x0, then the youngest writer first. A load in EX has
    // no value yet, so it is excluded here and handled by the hazard stall.
    // WB must be bypassed because the register file writes on the same edge
    // that would capture its (still old) combinational read data.
    function automatic logic [XLEN-1:0] selectOperand(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rfData,
        input logic            exOk,
        input logic [4:0]      exRd,
        input logic [XLEN-1:0] exVal,
        input logic            memWen,
        input logic [4:0]      memRd,
        input logic [XLEN-1:0] memVal,
        input logic            wbWen,
        input logic [4:0]      wbRd,
        input logic [XLEN-1:0] wbVal
    );
        if (src == 5'd0)                  return '0;
        else if (exOk && exRd == src)     return exVal;
        else if (memWen && memRd == src)  return memVal;
        else if (wbWen && wbRd == src)    return wbVal;
        else                              return rfData;
    endfunction

    // NOTE: every always_comb output gets a value on every path (here via a
    // default first), otherwise synthesis infers a latch.
    always_comb begin
        exFwdOk = 1'b0;
        exFwdOk = ex_valid && ex_reg_wen && !ex_mem_read;
        opA = selectOperand(id_rs1, rf_data_a, exFwdOk, ex_rd, ex_result,
                            mem_reg_wen, mem_rd, mem_data, wb_reg_wen, wb_rd, wb_data);
        opB = selectOperand(id_rs2, rf_data_b, exFwdOk, ex_rd, ex_result,
                            mem_reg_wen, mem_rd, mem_data, wb_reg_wen, wb_rd, wb_data);
    end

    // Load-use: the load's data only exists once it reaches MEM, so the
    // dependent instruction waits one cycle and then picks it up from mem_data.
    assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

    // A flushed ID instruction is wrong-path, so holding it would be pointless.
    assign stall  = hazard && !flush;
    assign bubble = flush || hazard || !id_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_wen   <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_pc        <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_ctrl      <= '0;
        end else if (bubble) begin
            // A bubble clears every field, so it can never write state.
            ex_valid     <= 1'b0;
            ex_reg_wen   <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_pc        <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_ctrl      <= '0;
        end else begin
            ex_valid     <= 1'b1;
            ex_reg_wen   <= id_reg_wen;
            ex_mem_read  <= id_mem_read;
            ex_mem_write <= id_mem_write;
            ex_pc        <= id_pc;
            ex_op_a      <= opA;
            ex_op_b      <= opB;
            ex_imm       <= id_imm;
            ex_rd        <= id_rd;
            ex_ctrl      <= id_ctrl;
        end
    end

    // Saturating stall counter: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Scoreboard bench for id_ex_stage. Each driven ID cycle pushes the
//   expected EX register contents; one clock later the entry is popped and
//   compared. The counter is narrowed to 4 bits to reach saturation quickly.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1, id_rs2;
    logic              id_use_rs1, id_use_rs2;
    logic [4:0]        id_rd;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_reg_wen, id_mem_read, id_mem_write;
    logic [XLEN-1:0]   rf_data_a, rf_data_b, ex_result;
    logic [4:0]        mem_rd, wb_rd;
    logic              mem_reg_wen, wb_reg_wen;
    logic [XLEN-1:0]   mem_data, wb_data;
    logic              flush;
    logic              stall;
    logic              ex_valid, ex_reg_wen, ex_mem_read, ex_mem_write;
    logic [XLEN-1:0]   ex_pc, ex_op_a, ex_op_b, ex_imm;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .id_reg_wen(id_reg_wen),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_reg_wen(mem_reg_wen), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen), .wb_data(wb_data),
        .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_reg_wen(ex_reg_wen), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_op_a(ex_op_a),
        .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              valid, reg_wen, mem_read, mem_write;
        logic [XLEN-1:0]   pc, op_a, op_b, imm;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt_model = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_bypass();
        ex_result   = '0;
        mem_rd      = '0; mem_reg_wen = 1'b0; mem_data = '0;
        wb_rd       = '0; wb_reg_wen  = 1'b0; wb_data  = '0;
        flush       = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [7:0] ctrl,
                         input logic wen, input logic mr, input logic mw);
        id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_rd = rd; id_imm = imm; id_ctrl = ctrl;
        id_reg_wen = wen; id_mem_read = mr; id_mem_write = mw;
    endtask

    function automatic exp_t capture(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.valid = 1'b1; e.reg_wen = id_reg_wen; e.mem_read = id_mem_read;
        e.mem_write = id_mem_write; e.pc = id_pc; e.op_a = a; e.op_b = b;
        e.imm = id_imm; e.rd = id_rd; e.ctrl = id_ctrl;
        return e;
    endfunction

    function automatic exp_t bubble_exp();
        exp_t e;
        e.valid = 1'b0; e.reg_wen = 1'b0; e.mem_read = 1'b0; e.mem_write = 1'b0;
        e.pc = '0; e.op_a = '0; e.op_b = '0; e.imm = '0; e.rd = '0; e.ctrl = '0;
        return e;
    endfunction

    // Push expectation, clock once, pop and compare against the EX register.
    task automatic step(input string tag, input exp_t e);
        exp_t got;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sb.pop_front();
        check({tag, ".valid"},  32'(ex_valid),     32'(got.valid));
        check({tag, ".wen"},    32'(ex_reg_wen),   32'(got.reg_wen));
        check({tag, ".mrd"},    32'(ex_mem_read),  32'(got.mem_read));
        check({tag, ".mwr"},    32'(ex_mem_write), 32'(got.mem_write));
        check({tag, ".pc"},     ex_pc,             got.pc);
        check({tag, ".op_a"},   ex_op_a,           got.op_a);
        check({tag, ".op_b"},   ex_op_b,           got.op_b);
        check({tag, ".imm"},    ex_imm,            got.imm);
        check({tag, ".rd"},     32'(ex_rd),        32'(got.rd));
        check({tag, ".ctrl"},   32'(ex_ctrl),      32'(got.ctrl));
    endtask

    task automatic bump_model();
        if (cnt_model != 15) cnt_model++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clear_bypass();
        issue('0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0);
        id_valid = 1'b0;
        rf_data_a = '0; rf_data_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 32'(ex_valid), 0);
        check("rst.op_a",  ex_op_a, 0);
        check("rst.rd",    32'(ex_rd), 0);
        check("rst.stall", 32'(stall), 0);
        check("rst.cnt",   32'(stall_cnt), 0);
        rst_n = 1'b1;

        // Pass-through: addi x6, x5, 7 with x5 = 0x1234 in the register file.
        rf_data_a = 32'h1234; rf_data_b = '0;
        issue(32'h100, 5, 0, 1, 0, 6, 7, 8'h13, 1, 0, 0);
        step("pass", capture(32'h1234, 0));

        // Forward priority on x5.
        issue(32'h104, 0, 0, 0, 0, 5, 1, 8'h13, 1, 0, 0);
        step("fwdA", capture(0, 0));
        ex_result = 32'hA; mem_rd = 5; mem_reg_wen = 1; mem_data = 32'hB;
        wb_rd = 5; wb_reg_wen = 1; wb_data = 32'hC; rf_data_a = 32'h99;
        issue(32'h108, 5, 0, 1, 0, 6, 2, 8'h33, 1, 0, 0);
        step("fwd_ex", capture(32'hA, 0));
        issue(32'h10C, 5, 0, 1, 0, 0, 3, 8'h33, 1, 0, 0);
        step("fwd_mem", capture(32'hB, 0));
        mem_reg_wen = 0;
        issue(32'h110, 5, 0, 1, 0, 0, 4, 8'h33, 1, 0, 0);
        step("fwd_wb", capture(32'hC, 0));
        mem_rd = 0; mem_reg_wen = 1; wb_rd = 0; wb_reg_wen = 1;
        rf_data_a = 32'h77; rf_data_b = 32'h77;
        issue(32'h114, 0, 0, 1, 1, 0, 5, 8'h33, 0, 0, 0);
        step("fwd_x0", capture(0, 0));

        // WB same-cycle bypass on rs2 for a store.
        clear_bypass();
        wb_rd = 7; wb_reg_wen = 1; wb_data = 32'hDEAD; rf_data_b = '0;
        issue(32'h118, 0, 7, 1, 1, 0, 8, 8'h23, 0, 0, 1);
        step("wb_byp", capture(0, 32'hDEAD));

        // Invalid ID slot becomes a bubble even with non-zero fields.
        clear_bypass();
        issue(32'h11C, 3, 4, 1, 1, 3, 9, 8'h33, 1, 1, 1);
        id_valid = 1'b0;
        step("invalid", bubble_exp());

        // Load-use: lw x8 then add x9, x8, x1.
        rf_data_a = 32'h40; rf_data_b = '0;
        issue(32'h120, 1, 0, 1, 0, 8, 4, 8'h03, 1, 1, 0);
        #1 check("lw.stall", 32'(stall), 0);
        step("lw", capture(32'h40, 0));
        rf_data_a = '0; rf_data_b = 32'h40;
        issue(32'h124, 8, 1, 1, 1, 9, 0, 8'h33, 1, 0, 0);
        #1 check("lu.stall", 32'(stall), 1);
        step("lu.bubble", bubble_exp());
        bump_model();
        check("lu.cnt", 32'(stall_cnt), 32'(cnt_model));
        mem_rd = 8; mem_reg_wen = 1; mem_data = 32'h55;
        #1 check("lu.retry_stall", 32'(stall), 0);
        step("lu.retry", capture(32'h55, 32'h40));
        check("lu.cnt_hold", 32'(stall_cnt), 32'(cnt_model));

        // Unused source matching a load destination must not stall.
        clear_bypass();
        rf_data_a = 32'h40; rf_data_b = '0;
        issue(32'h128, 1, 0, 1, 0, 8, 4, 8'h03, 1, 1, 0);
        step("lw2", capture(32'h40, 0));
        rf_data_a = 32'h66;
        issue(32'h12C, 8, 0, 0, 0, 10, 0, 8'h13, 1, 0, 0);
        #1 check("nouse.stall", 32'(stall), 0);
        step("nouse", capture(32'h66, 0));

        // Flush together with a hazard: no stall, bubble, counter unchanged.
        rf_data_a = 32'h40;
        issue(32'h130, 1, 0, 1, 0, 8, 4, 8'h03, 1, 1, 0);
        step("lw3", capture(32'h40, 0));
        issue(32'h134, 8, 1, 1, 1, 9, 0, 8'h33, 1, 0, 0);
        flush = 1'b1;
        #1 check("flush.stall", 32'(stall), 0);
        step("flush.haz", bubble_exp());
        check("flush.cnt", 32'(stall_cnt), 32'(cnt_model));
        issue(32'h138, 0, 0, 0, 0, 2, 1, 8'h13, 1, 0, 0);
        step("flush.plain", bubble_exp());
        flush = 1'b0;

        // Saturation: twenty load-use stalls on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            rf_data_a = 32'h40;
            issue(32'h200 + 32'(i * 8), 1, 0, 1, 0, 8, 4, 8'h03, 1, 1, 0);
            step("sat.lw", capture(32'h40, 0));
            issue(32'h204 + 32'(i * 8), 8, 1, 1, 1, 9, 0, 8'h33, 1, 0, 0);
            #1 check("sat.stall", 32'(stall), 1);
            step("sat.bubble", bubble_exp());
            bump_model();
            check("sat.cnt", 32'(stall_cnt), 32'(cnt_model));
        end
        check("sat.final", 32'(stall_cnt), 15);

        // Asynchronous reset in the middle of a stall.
        issue(32'h300, 1, 0, 1, 0, 8, 4, 8'h03, 1, 1, 0);
        step("pre_rst.lw", capture(32'h40, 0));
        issue(32'h304, 8, 1, 1, 1, 9, 0, 8'h33, 1, 0, 0);
        #1 check("pre_rst.stall", 32'(stall), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(ex_valid), 0);
        check("arst.mrd",   32'(ex_mem_read), 0);
        check("arst.rd",    32'(ex_rd), 0);
        check("arst.op_a",  ex_op_a, 0);
        check("arst.pc",    ex_pc, 0);
        check("arst.stall", 32'(stall), 0);
        check("arst.cnt",   32'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        id_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
